serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 136 +++++++++++++
 tb/tb_serial_adder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock with a start/busy/done handshake.
// Optional signed-overflow output V is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             busy,
  output logic             done
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             v_q, v_d;
`endif

  // Full-adder slice: two half-adder cells plus an OR for the carry.
  logic ha0_s, ha0_c, ha1_c, sum_bit, carry_next;
  assign ha0_s      = a_q[0] ^ b_q[0];
  assign ha0_c      = a_q[0] & b_q[0];
  assign sum_bit    = ha0_s ^ c_q;
  assign ha1_c      = ha0_s & c_q;
  assign carry_next = ha0_c | ha1_c;

  // Sum bits enter at the MSB so the partial register is aligned after WIDTH shifts.
  logic [WIDTH-1:0] part_shift;
  generate
    if (WIDTH == 1) begin : g_part_w1
      assign part_shift = sum_bit;
    end else begin : g_part_wn
      assign part_shift = {sum_bit, part_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    v_d     = v_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = Cin;
          part_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        part_d = part_shift;
        c_d    = carry_next;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          s_d     = part_shift;
          cout_d  = carry_next;
`ifdef SERIAL_ADDER_OVF_EN
          v_d     = c_q ^ carry_next;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
`ifdef SERIAL_ADDER_OVF_EN
  assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8 main instance, WIDTH=1 boundary instance).
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic [7:0] s;
  logic       cout, busy, done;

  logic       start1;
  logic [0:0] a1, b1, s1;
  logic       cin1, cout1, busy1, done1;

`ifdef SERIAL_ADDER_OVF_EN
  logic v, v1;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .Cin(cin),
    .S(s), .Cout(cout), .busy(busy), .done(done)
`ifdef SERIAL_ADDER_OVF_EN
    , .V(v)
`endif
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .S(s1), .Cout(cout1), .busy(busy1), .done(done1)
`ifdef SERIAL_ADDER_OVF_EN
    , .V(v1)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts from idle, scrambles inputs while busy, checks latency and result.
  task automatic do_add(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                        input logic [7:0] exp_s, input logic exp_c, input string name);
    int n;
    a = xa; b = xb; cin = xc; start = 1'b1;
    step();
    start = 1'b0; a = ~xa; b = ~xb; cin = ~xc;
    n = 0;
    while (busy && n < 40) begin
      n++;
      step();
    end
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("FAIL %s busy_cycles: got %0d expected 8", name, n);
    end
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s done_pulse: got %b expected 1", name, done);
    end
    tests_run++;
    if (s !== exp_s || cout !== exp_c) begin
      tests_failed++;
      $display("FAIL %s result: got S=%h Cout=%b expected S=%h Cout=%b", name, s, cout, exp_s, exp_c);
    end
    $display("[TB] %s: %h + %h + %b -> S=%h Cout=%b", name, xa, xb, xc, s, cout);
    step();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s done_width: got %b expected 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
    repeat (3) step();
    tests_run++;
    if (s !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: got S=%h Cout=%b busy=%b done=%b expected all 0", s, cout, busy, done);
    end
    tests_run++;
    if (s1 !== 1'b0 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state_w1: got S=%b busy=%b done=%b expected all 0", s1, busy1, done1);
    end
    $display("[TB] reset held with start=1: S=%h busy=%b done=%b", s, busy, done);
    rst = 1'b0; start = 1'b0; start1 = 1'b0;
    step();
  endtask

  task automatic test_basic();
    do_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic");
  endtask

  task automatic test_carry();
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "carry_out");
    do_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "carry_in");
    do_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "all_ones");
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [7:0] s_seen;
    logic c_seen;
    dones = 0; s_seen = 8'hXX; c_seen = 1'bx;
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        s_seen = s;
        c_seen = cout;
      end
      step();
    end
    tests_run++;
    if (dones !== 1) begin
      tests_failed++;
      $display("FAIL ignore_done_count: got %0d expected 1", dones);
    end
    tests_run++;
    if (s_seen !== 8'h46 || c_seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_result: got S=%h Cout=%b expected S=46 Cout=0", s_seen, c_seen);
    end
    $display("[TB] ignore_start: 12 + 34 with stray start -> S=%h dones=%0d", s_seen, dones);
  endtask

  task automatic test_back_to_back();
    int done_at[$];
    int n;
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    for (int i = 0; i < 36; i++) begin
      step();
      if (done) begin
        done_at.push_back(i);
        tests_run++;
        if (s !== 8'h30 || cout !== 1'b0) begin
          tests_failed++;
          $display("FAIL b2b_result: got S=%h Cout=%b expected S=30 Cout=0", s, cout);
        end
        $display("[TB] back_to_back: done at step %0d S=%h", i, s);
      end
    end
    tests_run++;
    if (done_at.size() < 3) begin
      tests_failed++;
      $display("FAIL b2b_count: got %0d expected at least 3", done_at.size());
    end else begin
      for (int k = 1; k < done_at.size(); k++) begin
        tests_run++;
        if (done_at[k] - done_at[k-1] !== 9) begin
          tests_failed++;
          $display("FAIL b2b_interval: got %0d expected 9", done_at[k] - done_at[k-1]);
        end
      end
    end
    start = 1'b0;
    n = 0;
    while ((busy || done) && n < 20) begin
      n++;
      step();
    end
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drain: got busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    tests_run++;
    if (s !== 8'h00 || cout !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: got S=%h Cout=%b busy=%b done=%b expected all 0", s, cout, busy, done);
    end
    $display("[TB] reset_mid: aborted AA + 55, S=%h busy=%b", s, busy);
    rst = 1'b0;
    step();
    do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_reset");
  endtask

  task automatic test_width1();
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    tests_run++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_busy: got busy=%b done=%b expected 1 0", busy1, done1);
    end
    step();
    tests_run++;
    if (done1 !== 1'b1 || busy1 !== 1'b0 || s1 !== 1'b1 || cout1 !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1_result: got done=%b busy=%b S=%b Cout=%b expected 1 0 1 1", done1, busy1, s1, cout1);
    end
    $display("[TB] width1: 1 + 1 + 1 -> S=%b Cout=%b", s1, cout1);
    a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    tests_run++;
    if (done1 !== 1'b1 || s1 !== 1'b1 || cout1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1_result2: got done=%b S=%b Cout=%b expected 1 1 0", done1, s1, cout1);
    end
    $display("[TB] width1: 1 + 0 + 0 -> S=%b Cout=%b", s1, cout1);
    step();
  endtask

`ifdef SERIAL_ADDER_OVF_EN
  task automatic test_ovf();
    do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, "ovf_pos");
    tests_run++;
    if (v !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_pos_v: got %b expected 1", v);
    end
    do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ovf_none");
    tests_run++;
    if (v !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_none_v: got %b expected 0", v);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_width1();
`ifdef SERIAL_ADDER_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
